// File: rtl/seq_ctrl_pkg.sv
// ============================================================================
// Module   : seq_ctrl_pkg
// Brief    : State encoding and the saturating counter helper for the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Holds at max_value instead of wrapping.
  function automatic int unsigned sat_inc(input int unsigned value,
                                          input int unsigned max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shifter.sv
// ============================================================================
// Module   : piso_shifter
// Brief    : Parallel-load, shift-left register presenting its MSB serially.
// Revision : 1.0
// ============================================================================
`default_nettype none

module piso_shifter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;

  // Load wins over shift; the two are never requested together by the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_detect_sequencer.sv
// ============================================================================
// Module   : seq_detect_sequencer
// Brief    : Serializes words into a sequence-detector FSM and reports hit counts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_detect_sequencer
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned CLEAR_PER_WORD = 1,
  parameter int unsigned DET_MEALY      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              det_x,
  output logic              det_clr,
  input  logic              det_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int unsigned      BC_W       = $clog2(WORD_W);
  localparam logic [BC_W-1:0]  C_LAST_BIT = BC_W'(WORD_W - 1);
  localparam int unsigned      C_CNT_MAX  = (32'd1 << CNT_W) - 32'd1;

  state_e             state_q;
  logic [BC_W-1:0]    bit_cnt_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic [CNT_W-1:0]   hit_cnt_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   out_count_q;
  logic               busy_q;
  logic               shreg_msb;
  logic               accept;
  logic               count_en;

  assign accept = (state_q == ST_IDLE) && in_valid && in_ready_q;

  // A Moore detector answers one cycle late, so its first SHIFT sample is
  // skipped and the missing one is taken in DRAIN instead.
  assign count_en = ((state_q == ST_SHIFT) && ((DET_MEALY != 0) || (bit_cnt_q != '0)))
                  || (state_q == ST_DRAIN);

  assign hit_cnt_d = (count_en && det_y)
                   ? CNT_W'(sat_inc(32'(hit_cnt_q), C_CNT_MAX))
                   : hit_cnt_q;

  piso_shifter #(
    .WIDTH (WORD_W)
  ) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .shift_i (state_q == ST_SHIFT),
    .data_i  (in_word),
    .msb_o   (shreg_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bit_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (CLEAR_PER_WORD != 0) ? ST_CLEAR : ST_SHIFT;
          end
        end
        ST_CLEAR: begin
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          hit_cnt_q <= hit_cnt_d;
          bit_cnt_q <= bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == C_LAST_BIT) begin
            if (DET_MEALY != 0) begin
              out_valid_q <= 1'b1;
              out_count_q <= hit_cnt_d;
              state_q     <= ST_REPORT;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          hit_cnt_q   <= hit_cnt_d;
          out_valid_q <= 1'b1;
          out_count_q <= hit_cnt_d;
          state_q     <= ST_REPORT;
        end
        ST_REPORT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign busy      = busy_q;
  assign det_x     = (state_q == ST_SHIFT) && shreg_msb;
  // Combinational on reset so the detector clears on the same edge as this block.
  assign det_clr   = reset || (state_q == ST_CLEAR);

endmodule

`default_nettype wire
